// File: rtl/ecc_parity_framer.sv
// Systematic codeword framer: passes K data words, then appends D = N-K rotated-XOR parity words.
// The output is a single register slot with a ready/valid handshake, widened to 32 bits.
module ecc_parity_framer #(
    parameter int unsigned N = 5,
    parameter int unsigned K = 3,
    parameter int unsigned W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [31:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sop,
    output logic          out_eop,
    output logic          out_par
);

    localparam int unsigned D  = N - K;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned JW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic {StData, StParity} state_t;

    state_t         r_state, w_state_d;
    logic [IW-1:0]  r_i, w_i_d;
    logic [JW-1:0]  r_j, w_j_d;
    logic [W-1:0]   r_word, w_word_d;
    logic           r_valid, w_valid_d;
    logic           r_sop, w_sop_d;
    logic           r_eop, w_eop_d;
    logic           r_par, w_par_d;
    logic [W-1:0]   r_acc [D];
    logic [W-1:0]   w_acc_d [D];

    logic           w_slot_free;
    logic           w_accept;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int unsigned amt);
        logic [2*W-1:0] t;
        t = {x, x} << amt;
        return t[2*W-1:W];
    endfunction

    assign w_slot_free = !r_valid || out_ready;
    assign in_ready    = (r_state == StData) && w_slot_free;
    assign w_accept    = in_valid && in_ready;

    assign out_data  = {{(32-W){1'b0}}, r_word};
    assign out_valid = r_valid;
    assign out_sop   = r_sop;
    assign out_eop   = r_eop;
    assign out_par   = r_par;

    always_comb begin
        w_state_d = r_state;
        w_i_d     = r_i;
        w_j_d     = r_j;
        w_word_d  = r_word;
        w_valid_d = r_valid;
        w_sop_d   = r_sop;
        w_eop_d   = r_eop;
        w_par_d   = r_par;
        w_acc_d   = r_acc;

        unique case (r_state)
            StData: begin
                if (w_accept) begin
                    w_word_d  = in_data;
                    w_valid_d = 1'b1;
                    w_sop_d   = (r_i == '0);
                    w_par_d   = 1'b0;
                    w_eop_d   = 1'b0;
                    // Parity j rotates data word i left by (i*j) mod W.
                    for (int unsigned jj = 0; jj < D; jj++) begin
                        w_acc_d[jj] = r_acc[jj] ^ rotl(in_data, (32'(r_i) * jj) % W);
                    end
                    if (r_i == IW'(K - 1)) begin
                        w_i_d     = '0;
                        w_state_d = StParity;
                    end else begin
                        w_i_d = r_i + IW'(1);
                    end
                end else if (w_slot_free) begin
                    w_valid_d = 1'b0;
                end
            end
            StParity: begin
                if (w_slot_free) begin
                    w_word_d  = r_acc[r_j];
                    w_valid_d = 1'b1;
                    w_par_d   = 1'b1;
                    w_sop_d   = 1'b0;
                    w_eop_d   = (r_j == JW'(D - 1));
                    if (r_j == JW'(D - 1)) begin
                        w_j_d     = '0;
                        w_state_d = StData;
                        for (int unsigned jj = 0; jj < D; jj++) begin
                            w_acc_d[jj] = '0;
                        end
                    end else begin
                        w_j_d = r_j + JW'(1);
                    end
                end
            end
            default: w_state_d = StData;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StData;
            r_i     <= '0;
            r_j     <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_par   <= 1'b0;
            for (int unsigned jj = 0; jj < D; jj++) begin
                r_acc[jj] <= '0;
            end
        end else begin
            r_state <= w_state_d;
            r_i     <= w_i_d;
            r_j     <= w_j_d;
            r_word  <= w_word_d;
            r_valid <= w_valid_d;
            r_sop   <= w_sop_d;
            r_eop   <= w_eop_d;
            r_par   <= w_par_d;
            r_acc   <= w_acc_d;
        end
    end

endmodule

// File: doc/ecc_parity_framer.md
Name: ecc_parity_framer

Overview:
- Upstream stage of the fixed-depth delay line.
- Groups a stream of 16-bit data words into systematic codewords of N words: K data words pass straight through, followed by D = N-K generated parity words.
- Output is 32 bits wide, upper 16 bits zero, so it feeds the delay line's 32-bit data input directly.
- Sideband flags mark codeword start, codeword end and parity words for downstream alignment.

Parameters:
- N, 5, codeword length in words.
- K, 3, data words per codeword. Require 1 <= K < N and N-K <= 4.
- W, 16, data word width in bits.
- D (localparam), N-K, parity words per codeword. Matches the delay depth.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_data  in  W  data word
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  32  {16'b0, word}; word is a data word or a parity word
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data this cycle
- out_sop  out  1  out_data is data word 0 of a codeword
- out_eop  out  1  out_data is the last parity word (P[D-1])
- out_par  out  1  out_data is a parity word

Behaviour:
- Reset is asynchronous and active-high:
  - out_data=0, out_valid=0, out_sop=0, out_eop=0, out_par=0
  - state=DATA, word counter i=0, parity counter j=0, all accumulators acc[0..D-1]=0
- Reset asserted mid-codeword discards the partial codeword. The first word accepted after reset is word 0.
- Output slot is a single register. slot_free = !out_valid || out_ready.
- in_ready = (state==DATA) && slot_free. It is combinational and never depends on in_valid.
- Accept = in_valid && in_ready. On accept:
  - out_data <= in_data, out_valid <= 1, out_sop <= (i==0), out_par <= 0, out_eop <= 0
  - acc[j'] <= acc[j'] ^ rotl(in_data, (i*j') mod W) for every j' in 0..D-1
  - i <= i+1
  - When i==K-1: i <= 0 and state <= PARITY.
- Latency: a data word accepted at edge t is on out_data with out_valid=1 after edge t. That is one cycle.
- PARITY state, on each edge with slot_free:
  - out_data <= acc[j], out_valid <= 1, out_par <= 1, out_sop <= 0, out_eop <= (j==D-1)
  - j <= j+1
- When j==D-1 is loaded:
  - j <= 0, all acc <= 0, state <= DATA
  - in_ready may assert on the next cycle.
- Parity definitions:
  - P0 is the plain XOR of all data words.
  - P1 is the XOR of each data word i rotated left by i.
  - Pj uses a rotation of (i*j) mod W, wrapping within W bits.
- DATA state with no accept and slot_free: out_valid <= 0. Other output fields hold; downstream ignores them.
- Backpressure: while out_valid=1 and out_ready=0, out_data and all flags hold stable. No accept or parity load takes place.
- Throughput: N cycles per codeword with in_valid=1 and out_ready=1 held constant. There are no bubbles between codewords.
- in_valid low mid-codeword: the block waits in DATA, keeping i and acc. No timeout.
- out_data[31:16] is always 0.

Test Plan:
- Reset, then no input: out_valid=0, in_ready=1, out_data=0. Assert rst asynchronously mid-cycle: outputs clear immediately, without waiting for a clock edge.
- Inputs 0x0001, 0x0002, 0x0004, out_ready=1:
  - out stream 0x0001(sop), 0x0002, 0x0004, 0x0007(par), 0x0015(par, eop) on consecutive cycles
  - in_ready=0 for exactly 2 cycles.
- Rotation wrap test, inputs 0x8000, 0x8000, 0x8000: parity words 0x8000 then 0x8003 (eop).
- Backpressure: hold out_ready=0 for 3 cycles while the P0 of the codeword above is presented:
  - out_data stays 0x0007 with out_par=1
  - in_ready=0
  - release gives 0x0015 next
  - the next codeword's word 0 is accepted on the following cycle.
- Two back-to-back codewords, (0x1111, 0x2222, 0x4444) then (0x0001, 0x0002, 0x0004):
  - first parity pair is 0x7777 and rotl(0x1111,0) ^ rotl(0x2222,1) ^ rotl(0x4444,2) = 0x1111 ^ 0x4444 ^ 0x1111 = 0x4444
  - second pair is 0x0007, 0x0015, proving the accumulators clear between codewords.
- Reset after 2 data words, then inputs 0x0001, 0x0002, 0x0004: output matches the single-codeword case exactly, with out_sop on 0x0001.
